l2_arbiter: RTL and testbench
=============================

Name: l2_arbiter

Overview:
- Shares the single L2 cache between the two core-side L1 miss paths of the dual-core processor.
- Accepts one request per core through a req/ack handshake and arbitrates between them round-robin.
- Drives the L2 command vector and enable for exactly one transaction at a time, captures the L2's combinational data and hit/miss result into registers, and returns them to the granted core.

Parameters:
- TAG_WIDTH, 4, tag field width.
- DATA_WIDTH, 8, data field width.
- OPCODE_WIDTH, 2, opcode field width (00 FLASH, 01 READ, 10 WRITE, 11 illegal).
- LINE_WIDTH, OPCODE_WIDTH+TAG_WIDTH+DATA_WIDTH, L2 command vector width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- c0_req  in  1  core 0 request; held high until c0_ack.
- c0_op  in  OPCODE_WIDTH  core 0 opcode.
- c0_tag  in  TAG_WIDTH  core 0 tag.
- c0_wdata  in  DATA_WIDTH  core 0 write data.
- c0_ack  out  1  one-cycle completion pulse to core 0.
- c0_rdata  out  DATA_WIDTH  registered L2 data for core 0; valid while c0_ack=1, held afterwards.
- c0_hit  out  1  registered L2 hit/miss for core 0; valid while c0_ack=1.
- c1_req, c1_op, c1_tag, c1_wdata, c1_ack, c1_rdata, c1_hit: same as core 0, for core 1.
- l2_vector  out  LINE_WIDTH  {op, tag, wdata} to the L2 vector input.
- l2_enable  out  1  L2 enable.
- l2_data  in  DATA_WIDTH  L2 data output.
- l2_hit  in  1  L2 hit/miss output.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - state=IDLE, rr_last=1 (core 0 has priority first).
  - All acks 0, all rdata 0, all hit 0.
  - l2_vector=0, l2_enable=0.
- FSM has three states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - l2_enable=0 and l2_vector=0.
  - A core is eligible if its req=1 and its ack is 0 this cycle, so a core dropping req after its ack is never re-served.
  - One eligible core: grant it.
  - Both eligible: grant the core other than rr_last.
  - On grant, latch {op, tag, wdata} into cmd_q and record the grant id.
  - If the latched op=11, go to a one-cycle response with rdata=0, hit=0 and no L2 access: ack asserts the next cycle and the FSM returns to IDLE.
  - Otherwise go to ISSUE.
- ISSUE: l2_vector=cmd_q, l2_enable=1, for one settle cycle. Next state CAPTURE.
- CAPTURE:
  - l2_vector=cmd_q, l2_enable=1, so the vector is stable for 2 cycles.
  - At the edge, register l2_data/l2_hit into the granted core's rdata/hit.
  - At the same edge, pulse that core's ack=1 for one cycle, set rr_last=grant id, and go to IDLE.
- Latency: req sampled at edge E0 in IDLE, then ack high in the cycle after E2 (3 cycles req-to-ack). Back-to-back throughput is one transaction per 3 cycles.
- The arbiter holds no cache state. FLASH and WRITE responses are forwarded unmodified; WRITE rdata is whatever the L2 drives.
- Fairness: with both cores requesting continuously, grants strictly alternate, so the worst-case wait is one transaction.
- Request changes: the arbiter ignores changes on op/tag/wdata after the grant edge, because cmd_q is used.
- Reset mid-transaction:
  - At the reset edge the FSM goes to IDLE and l2_enable deasserts.
  - No ack is issued for the aborted transaction. The core must re-request.
- At most one ack is high in any cycle. The two acks are never simultaneous.

Decomposition:
- Shared package holds:
  - opcode constants OP_FLASH/OP_READ/OP_WRITE/OP_ILLEGAL;
  - FSM state encoding S_IDLE/S_ISSUE/S_CAPTURE;
  - default widths (4/8/2).
- One natural sub-module: rr_arb2, a two-requester round-robin picker. Inputs are req[1:0] and last; outputs are gnt[1:0] (one-hot) and gnt_id. It is purely combinational.
- The FSM, command latch and response registers stay in l2_arbiter.

Test Plan:
- Reset then single READ: c0 op=01, tag=1001 -> l2_vector=01_1001_00000000 and l2_enable=1 for 2 cycles; c0_ack pulses 3 cycles after req, c0_rdata=0xB2 and c0_hit=1 (L2 preset contents). c1_ack stays 0.
- Simultaneous requests after reset: c0 READ tag 1010, c1 READ tag 1110 at the same edge -> c0 served first (rdata 0x55), then c1 (rdata 0xAA). Acks are 3 cycles apart and never overlap.
- Continuous contention: both req held high for 12 cycles -> grant order 0,1,0,1 with 4 acks total.
- WRITE then READ from c1: WRITE tag 0101 data 0x3C, then READ tag 0101 -> second c1_rdata=0x3C, c1_hit=1.
- Illegal op=11 on c0 -> l2_enable never asserts; c0_ack pulses 2 cycles after req with c0_rdata=0 and c0_hit=0.
- Reset asserted during ISSUE -> next cycle l2_enable=0, state IDLE, no ack. A re-request then completes normally.

Source files
------------

// File: rtl/l2_arbiter_pkg.sv
// Shared constants for the dual-core L2 arbiter: opcodes, FSM encoding, default widths.
package l2_arbiter_pkg;

    localparam int unsigned TAG_WIDTH_DEF    = 4;
    localparam int unsigned DATA_WIDTH_DEF   = 8;
    localparam int unsigned OPCODE_WIDTH_DEF = 2;

    localparam logic [1:0] OP_FLASH   = 2'b00;
    localparam logic [1:0] OP_READ    = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE    = 2'd0;
    localparam state_t S_ISSUE   = 2'd1;
    localparam state_t S_CAPTURE = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; on contention the requester other than last_i wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_o    = 2'b00;
        gnt_id_o = 1'b0;
        if (req_i == 2'b11) begin
            gnt_id_o = ~last_i;
        end else begin
            gnt_id_o = req_i[1];
        end
        if (req_i != 2'b00) begin
            gnt_o = gnt_id_o ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 between two L1 miss paths; one transaction at a time,
// command held stable on the L2 for two cycles and the result registered back to the winner.
module l2_arbiter
    import l2_arbiter_pkg::*;
#(
    parameter int unsigned TAG_WIDTH    = TAG_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned OPCODE_WIDTH = OPCODE_WIDTH_DEF,
    parameter int unsigned LINE_WIDTH   = OPCODE_WIDTH + TAG_WIDTH + DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    c0_req,
    input  logic [OPCODE_WIDTH-1:0] c0_op,
    input  logic [TAG_WIDTH-1:0]    c0_tag,
    input  logic [DATA_WIDTH-1:0]   c0_wdata,
    output logic                    c0_ack,
    output logic [DATA_WIDTH-1:0]   c0_rdata,
    output logic                    c0_hit,
    input  logic                    c1_req,
    input  logic [OPCODE_WIDTH-1:0] c1_op,
    input  logic [TAG_WIDTH-1:0]    c1_tag,
    input  logic [DATA_WIDTH-1:0]   c1_wdata,
    output logic                    c1_ack,
    output logic [DATA_WIDTH-1:0]   c1_rdata,
    output logic                    c1_hit,
    output logic [LINE_WIDTH-1:0]   l2_vector,
    output logic                    l2_enable,
    input  logic [DATA_WIDTH-1:0]   l2_data,
    input  logic                    l2_hit
);

    state_t                  state_q, state_d;
    logic [LINE_WIDTH-1:0]   cmd_q, cmd_d;
    logic                    gnt_id_q, gnt_id_d;
    logic                    illegal_q, illegal_d;
    logic                    rr_last_q, rr_last_d;
    logic [1:0]              ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                    hit0_q, hit0_d, hit1_q, hit1_d;

    logic [1:0]              eligible;
    logic [1:0]              arb_gnt;
    logic                    arb_id;
    logic [LINE_WIDTH-1:0]   new_cmd;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic                    resp_hit;

    // A core whose ack is high this cycle is finishing, so its stale req must not re-win.
    assign eligible = {c1_req & ~ack_q[1], c0_req & ~ack_q[0]};

    rr_arb2 u_rr_arb2 (
        .req_i   (eligible),
        .last_i  (rr_last_q),
        .gnt_o   (arb_gnt),
        .gnt_id_o(arb_id)
    );

    assign new_cmd   = arb_id ? {c1_op, c1_tag, c1_wdata} : {c0_op, c0_tag, c0_wdata};
    assign resp_data = illegal_q ? '0 : l2_data;
    assign resp_hit  = illegal_q ? 1'b0 : l2_hit;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        gnt_id_d  = gnt_id_q;
        illegal_d = illegal_q;
        rr_last_d = rr_last_q;
        ack_d     = 2'b00;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        hit0_d    = hit0_q;
        hit1_d    = hit1_q;
        case (state_q)
            S_IDLE: begin
                if (|arb_gnt) begin
                    cmd_d     = new_cmd;
                    gnt_id_d  = arb_id;
                    illegal_d = (new_cmd[LINE_WIDTH-1 -: OPCODE_WIDTH] ==
                                 OPCODE_WIDTH'(OP_ILLEGAL));
                    // Illegal ops skip the settle cycle and answer without touching the L2.
                    state_d   = illegal_d ? S_CAPTURE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                ack_d[gnt_id_q] = 1'b1;
                if (gnt_id_q) begin
                    rdata1_d = resp_data;
                    hit1_d   = resp_hit;
                end else begin
                    rdata0_d = resp_data;
                    hit0_d   = resp_hit;
                end
                rr_last_d = gnt_id_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            gnt_id_q  <= 1'b0;
            illegal_q <= 1'b0;
            rr_last_q <= 1'b1;
            ack_q     <= 2'b00;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            hit0_q    <= 1'b0;
            hit1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            gnt_id_q  <= gnt_id_d;
            illegal_q <= illegal_d;
            rr_last_q <= rr_last_d;
            ack_q     <= ack_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            hit0_q    <= hit0_d;
            hit1_q    <= hit1_d;
        end
    end

    assign l2_enable = (state_q == S_ISSUE) || ((state_q == S_CAPTURE) && !illegal_q);
    assign l2_vector = l2_enable ? cmd_q : '0;

    assign c0_ack   = ack_q[0];
    assign c1_ack   = ack_q[1];
    assign c0_rdata = rdata0_q;
    assign c1_rdata = rdata1_q;
    assign c0_hit   = hit0_q;
    assign c1_hit   = hit1_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter with a small behavioural L2 (combinational read, clocked write).
module tb_l2_arbiter;
    import l2_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        c0_req, c1_req;
    logic [1:0]  c0_op, c1_op;
    logic [3:0]  c0_tag, c1_tag;
    logic [7:0]  c0_wdata, c1_wdata;
    logic        c0_ack, c1_ack;
    logic [7:0]  c0_rdata, c1_rdata;
    logic        c0_hit, c1_hit;
    logic [13:0] l2_vector;
    logic        l2_enable;
    logic [7:0]  l2_data;
    logic        l2_hit;

    int tests = 0;
    int fails = 0;
    int overlap = 0;

    logic [7:0] mem [16];
    logic       vld [16];

    always #5 clk = ~clk;

    l2_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .c0_req   (c0_req),
        .c0_op    (c0_op),
        .c0_tag   (c0_tag),
        .c0_wdata (c0_wdata),
        .c0_ack   (c0_ack),
        .c0_rdata (c0_rdata),
        .c0_hit   (c0_hit),
        .c1_req   (c1_req),
        .c1_op    (c1_op),
        .c1_tag   (c1_tag),
        .c1_wdata (c1_wdata),
        .c1_ack   (c1_ack),
        .c1_rdata (c1_rdata),
        .c1_hit   (c1_hit),
        .l2_vector(l2_vector),
        .l2_enable(l2_enable),
        .l2_data  (l2_data),
        .l2_hit   (l2_hit)
    );

    // L2 model: preset lines on reset, writes/flash on enabled edges.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= 8'h00;
                vld[i] <= 1'b0;
            end
            mem[9]  <= 8'hB2; vld[9]  <= 1'b1;
            mem[10] <= 8'h55; vld[10] <= 1'b1;
            mem[14] <= 8'hAA; vld[14] <= 1'b1;
        end else if (l2_enable) begin
            if (l2_vector[13:12] == OP_WRITE) begin
                mem[l2_vector[11:8]] <= l2_vector[7:0];
                vld[l2_vector[11:8]] <= 1'b1;
            end else if (l2_vector[13:12] == OP_FLASH) begin
                for (int i = 0; i < 16; i++) vld[i] <= 1'b0;
            end
        end
    end

    assign l2_data = mem[l2_vector[11:8]];
    assign l2_hit  = vld[l2_vector[11:8]];

    always @(negedge clk) if (c0_ack && c1_ack) overlap++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int core, input int max_cyc, output int cyc);
        logic found;
        found = 1'b0;
        cyc = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            cyc++;
            if ((core == 0) ? c0_ack : c1_ack) begin
                found = 1'b1;
                break;
            end
        end
        chk("ack_within_budget", 32'(found), 32'd1);
    endtask

    initial begin
        int lat;
        int nacks;
        logic [3:0] ord;

        reset = 1'b1;
        c0_req = 0; c0_op = OP_READ; c0_tag = 0; c0_wdata = 0;
        c1_req = 0; c1_op = OP_READ; c1_tag = 0; c1_wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_acks", {c1_ack, c0_ack}, 0);
        chk("rst_rdata", {c1_rdata, c0_rdata}, 0);
        chk("rst_hits", {c1_hit, c0_hit}, 0);
        chk("rst_en", l2_enable, 0);
        chk("rst_vec", l2_vector, 0);
        reset = 1'b0;

        // Single READ from core 0
        c0_req = 1; c0_op = OP_READ; c0_tag = 4'b1001; c0_wdata = 8'h00;
        @(negedge clk);
        chk("s1_en_issue", l2_enable, 1);
        chk("s1_vec_issue", l2_vector, 14'b01_1001_00000000);
        @(negedge clk);
        chk("s1_en_capture", l2_enable, 1);
        chk("s1_vec_capture", l2_vector, 14'b01_1001_00000000);
        chk("s1_no_early_ack", c0_ack, 0);
        @(negedge clk);
        chk("s1_ack", c0_ack, 1);
        chk("s1_rdata", c0_rdata, 8'hB2);
        chk("s1_hit", c0_hit, 1);
        chk("s1_c1_ack", c1_ack, 0);
        chk("s1_en_idle", l2_enable, 0);
        c0_req = 0;
        @(negedge clk);
        chk("s1_ack_pulse", c0_ack, 0);
        chk("s1_rdata_held", c0_rdata, 8'hB2);

        // Simultaneous requests right after reset: core 0 first
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        c0_req = 1; c0_op = OP_READ; c0_tag = 4'b1010;
        c1_req = 1; c1_op = OP_READ; c1_tag = 4'b1110;
        wait_ack(0, 6, lat);
        chk("s2_c0_lat", lat, 3);
        chk("s2_c0_rdata", c0_rdata, 8'h55);
        chk("s2_c1_not_yet", c1_ack, 0);
        c0_req = 0;
        wait_ack(1, 6, lat);
        chk("s2_c1_gap", lat, 3);
        chk("s2_c1_rdata", c1_rdata, 8'hAA);
        c1_req = 0;
        @(negedge clk);

        // Continuous contention: strict alternation
        c0_req = 1; c0_tag = 4'b1001;
        c1_req = 1; c1_tag = 4'b1110;
        nacks = 0;
        ord = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (c0_ack) begin nacks++; ord = {ord[2:0], 1'b0}; end
            if (c1_ack) begin nacks++; ord = {ord[2:0], 1'b1}; end
        end
        c0_req = 0; c1_req = 0;
        chk("s3_ack_count", nacks, 4);
        chk("s3_order", ord, 4'b0101);
        @(negedge clk);

        // WRITE then READ from core 1
        c1_req = 1; c1_op = OP_WRITE; c1_tag = 4'b0101; c1_wdata = 8'h3C;
        wait_ack(1, 6, lat);
        chk("s4_wr_lat", lat, 3);
        c1_req = 0;
        @(negedge clk);
        c1_req = 1; c1_op = OP_READ; c1_wdata = 8'h00;
        wait_ack(1, 6, lat);
        chk("s4_rd_lat", lat, 3);
        chk("s4_rd_rdata", c1_rdata, 8'h3C);
        chk("s4_rd_hit", c1_hit, 1);
        c1_req = 0;
        @(negedge clk);

        // Illegal opcode on core 0
        c0_req = 1; c0_op = OP_ILLEGAL; c0_tag = 4'b1001;
        @(negedge clk);
        chk("s5_en_c1", l2_enable, 0);
        chk("s5_no_ack_c1", c0_ack, 0);
        @(negedge clk);
        chk("s5_ack", c0_ack, 1);
        chk("s5_en_c2", l2_enable, 0);
        chk("s5_rdata", c0_rdata, 0);
        chk("s5_hit", c0_hit, 0);
        c0_req = 0;
        @(negedge clk);

        // Reset during ISSUE, then re-request
        c0_req = 1; c0_op = OP_READ; c0_tag = 4'b1001;
        @(negedge clk);
        chk("s6_en_issue", l2_enable, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("s6_en_after_rst", l2_enable, 0);
        chk("s6_vec_after_rst", l2_vector, 0);
        chk("s6_no_ack", c0_ack, 0);
        reset = 1'b0;
        wait_ack(0, 6, lat);
        chk("s6_rereq_lat", lat, 3);
        chk("s6_rereq_rdata", c0_rdata, 8'hB2);
        chk("s6_rereq_hit", c0_hit, 1);
        c0_req = 0;
        @(negedge clk);

        chk("acks_never_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
